sgd_rd_x_from_memory: RTL

SGD_RD_X_FROM_MEMORY -- requirements
Module: sgd_rd_x_from_memory

---
 rtl/sgd_rd_x_from_memory.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/sgd_rd_x_from_memory.sv
// Loads the model vector x from host memory over a 512-bit DMA read stream and
// scatters it, one bank word at a time, into the per-engine x-memory banks.
module sgd_rd_x_from_memory #(
  parameter int ENGINE_NUM = 8,
  parameter int BANK_WIDTH = 2048,
  parameter int DEPTH_BITS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [63:0]             addr_model,
  input  logic [31:0]             dimension,
  input  logic                    load_en,
  output logic                    load_done,
  output logic                    x_data_fetch_start,
  output logic [63:0]             x_data_fetch_addr,
  output logic [31:0]             x_data_fetch_length,
  input  logic [511:0]            x_data_in,
  input  logic                    x_data_in_valid,
  output logic                    x_data_in_ready,
  output logic [ENGINE_NUM-1:0]   x_mem_wr_en,
  output logic [DEPTH_BITS-1:0]   x_mem_wr_addr,
  output logic [BANK_WIDTH-1:0]   x_mem_wr_data,
  output logic [31:0]             state_counters
);

  localparam int SLICES        = BANK_WIDTH / 512;
  localparam int SLICE_W       = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam int ENG_W         = (ENGINE_NUM > 1) ? $clog2(ENGINE_NUM) : 1;
  localparam int FEATS_PER_ROW = ENGINE_NUM * BANK_WIDTH / 32;
  localparam int ROW_BYTES     = ENGINE_NUM * BANK_WIDTH / 8;

  localparam logic [SLICE_W-1:0] LAST_SLICE  = SLICE_W'(SLICES - 1);
  localparam logic [ENG_W-1:0]   LAST_ENGINE = ENG_W'(ENGINE_NUM - 1);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  state_t                 state;
  logic [31:0]            rows_r;
  logic [31:0]            rows_seen;
  logic [SLICE_W-1:0]     slice_idx;
  logic [ENG_W-1:0]       engine_idx;
  logic [DEPTH_BITS-1:0]  row_idx;

  logic [31:0] rows_calc;
  logic [31:0] fetch_len_calc;
  logic        beat_ok;
  logic        last_slice;
  logic        last_engine;
  logic        last_row;

  // Rows needed to hold `dimension` 32-bit features, rounded up.
  assign rows_calc      = dimension / 32'(FEATS_PER_ROW)
                        + {31'd0, |(dimension % 32'(FEATS_PER_ROW))};
  assign fetch_len_calc = rows_calc * 32'(ROW_BYTES);

  assign beat_ok     = x_data_in_valid & x_data_in_ready;
  assign last_slice  = (slice_idx == LAST_SLICE);
  assign last_engine = (engine_idx == LAST_ENGINE);
  assign last_row    = (rows_seen == rows_r - 32'd1);

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // flop samples the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state               <= IDLE;
      rows_r              <= '0;
      rows_seen           <= '0;
      slice_idx           <= '0;
      engine_idx          <= '0;
      row_idx             <= '0;
      load_done           <= 1'b0;
      x_data_fetch_start  <= 1'b0;
      x_data_fetch_addr   <= '0;
      x_data_fetch_length <= '0;
      x_data_in_ready     <= 1'b0;
      x_mem_wr_en         <= '0;
      x_mem_wr_addr       <= '0;
      x_mem_wr_data       <= '0;
      state_counters      <= '0;
    end else begin
      // NOTE: pulse outputs default low here so every path through the case
      // leaves them defined and they last exactly one cycle when set below.
      load_done          <= 1'b0;
      x_data_fetch_start <= 1'b0;
      x_mem_wr_en        <= '0;

      case (state)
        IDLE: begin
          if (load_en) begin
            rows_r         <= rows_calc;
            rows_seen      <= '0;
            slice_idx      <= '0;
            engine_idx     <= '0;
            row_idx        <= '0;
            state_counters <= '0;
            if (dimension == 32'd0) begin
              state <= DONE;
            end else begin
              state               <= CMD;
              x_data_fetch_start  <= 1'b1;
              x_data_fetch_addr   <= addr_model;
              x_data_fetch_length <= fetch_len_calc;
            end
          end
        end

        CMD: begin
          state           <= DATA;
          x_data_in_ready <= 1'b1;
        end

        DATA: begin
          if (beat_ok) begin
            state_counters <= state_counters + 32'd1;
            // The bank word is assembled in place in the write-data register;
            // it is only consumed in the cycle x_mem_wr_en is high.
            for (int k = 0; k < SLICES; k++) begin
              if (slice_idx == SLICE_W'(k)) x_mem_wr_data[k*512 +: 512] <= x_data_in;
            end
            if (last_slice) begin
              slice_idx     <= '0;
              x_mem_wr_en   <= ENGINE_NUM'(1) << engine_idx;
              x_mem_wr_addr <= row_idx;
              if (last_engine) begin
                engine_idx <= '0;
                row_idx    <= row_idx + DEPTH_BITS'(1);
                rows_seen  <= rows_seen + 32'd1;
                if (last_row) begin
                  state           <= DONE;
                  x_data_in_ready <= 1'b0;
                end
              end else begin
                engine_idx <= engine_idx + ENG_W'(1);
              end
            end else begin
              slice_idx <= slice_idx + SLICE_W'(1);
            end
          end
        end

        DONE: begin
          load_done <= 1'b1;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
